// File: rtl/stopwatch_pkg.sv
// Shared display constants for the stopwatch display consumers.
// Contents: active-low 7-segment patterns {dp,g,f,e,d,c,b,a} for BCD 0..9,
// the blank pattern, per-slot anode patterns (an[3] = leftmost digit),
// and the scan slot index type.
package stopwatch_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  localparam logic [3:0] AN_IDX0 = 4'b0111;
  localparam logic [3:0] AN_IDX1 = 4'b1011;
  localparam logic [3:0] AN_IDX2 = 4'b1101;
  localparam logic [3:0] AN_IDX3 = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Scan slot, left to right on the display.
  typedef enum logic [1:0] {
    IDX_MIN10 = 2'd0,
    IDX_MIN1  = 2'd1,
    IDX_SEC10 = 2'd2,
    IDX_SEC1  = 2'd3
  } digit_idx_e;

  // Anode pattern that enables the digit of a given scan slot.
  function automatic logic [3:0] an_for_idx(input digit_idx_e idx);
    logic [3:0] an_v;
    case (idx)
      IDX_MIN10: an_v = AN_IDX0;
      IDX_MIN1:  an_v = AN_IDX1;
      IDX_SEC10: an_v = AN_IDX2;
      IDX_SEC1:  an_v = AN_IDX3;
      default:   an_v = AN_OFF;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd_i  [3:0] BCD digit; codes above 9 decode to blank
//   seg_o  [7:0] active-low {dp,g,f,e,d,c,b,a}; dp is always off here
module bcd_seg_lut
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  // Digit decode table with blank fallback for non-BCD codes.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_blink.sv
// Stopwatch display stage: time-multiplexes four BCD digits onto a 4-digit
// common-anode 7-segment display and blinks the selected pair in adjust mode.
// All timing comes from clock-enable counters on clk (no derived clocks).
// Parameters (each must be >= 1):
//   REFRESH_DIV  clk cycles per digit slot
//   BLINK_DIV    clk cycles per blink phase
//   DP_SEP       1 = light the dp of the min1 digit as min/sec separator
// Ports:
//   clk, rst                  system clock, async active-high reset
//   min10, min1, sec10, sec1  BCD digits, left to right
//   adj                       adjust mode (level)
//   sel                       0 = blink seconds pair, 1 = blink minutes pair
//   an  [3:0]                 registered active-low anodes, an[3] leftmost
//   seg [7:0]                 registered active-low {dp,g,f,e,d,c,b,a}
module seg_scan_blink
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 250000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter bit          DP_SEP      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min10,
  input  logic [3:0] min1,
  input  logic [3:0] sec10,
  input  logic [3:0] sec1,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  digit_idx_e    idx_q, idx_d;
  logic          phase_q, phase_d;  // 1 = visible half of the blink period
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic [3:0]    digit_s;
  logic [7:0]    lut_seg_s;

  bcd_seg_lut u_lut (
    .bcd_i (digit_s),
    .seg_o (lut_seg_s)
  );

  // Slot timer and scan index; free-running regardless of adjust mode.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + {{(RW-1){1'b0}}, 1'b1};
    idx_d         = idx_q;
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      idx_d         = digit_idx_e'(idx_q + 2'd1);
    end else begin
      refresh_cnt_d = refresh_cnt_q + {{(RW-1){1'b0}}, 1'b1};
    end
  end

  // Blink timer: parked at the start of a visible phase outside adjust mode,
  // so each adjust entry begins visible.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b1;
    if (!adj) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
      phase_d     = phase_q;
    end
  end

  // Output function of the current slot; registered below for clean pins.
  always_comb begin
    digit_s = min10;
    case (idx_q)
      IDX_MIN10: digit_s = min10;
      IDX_MIN1:  digit_s = min1;
      IDX_SEC10: digit_s = sec10;
      IDX_SEC1:  digit_s = sec1;
      default:   digit_s = min10;
    endcase

    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    // idx_q[1] is 0 for the minutes pair, 1 for the seconds pair.
    if (adj && !phase_q && (sel ? !idx_q[1] : idx_q[1])) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = an_for_idx(idx_q);
      seg_d = {~(DP_SEP && (idx_q == IDX_MIN1)), lut_seg_s[6:0]};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= IDX_MIN10;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b1;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_blink.sv
// Bench for seg_scan_blink with REFRESH_DIV=4, BLINK_DIV=16. Two instances
// share the inputs: DP_SEP=0 and DP_SEP=1. The stimulus side pushes the
// expected outputs for every clock edge into a queue; a monitor pops and
// compares after each edge (or after an asynchronous reset probe).
module tb_seg_scan_blink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] min10 = 4'd0, min1 = 4'd0, sec10 = 4'd0, sec1 = 4'd0;
  logic       adj = 1'b0, sel = 1'b0;
  logic       probe = 1'b0;
  logic       done = 1'b0;
  logic [3:0] an0, an1;
  logic [7:0] seg0, seg1;

  typedef struct packed {
    logic [3:0]  an;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [15:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   s = 0;       // edges since reset release
  int   b = 0;       // consecutive prior edges with adj=1
  logic [15:0] tag_n = 16'd0;

  logic [7:0] seg_tab [0:15];
  logic [3:0] an_tab  [0:3];

  always #5 clk = ~clk;

  seg_scan_blink #(.REFRESH_DIV(4), .BLINK_DIV(16), .DP_SEP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .min10(min10), .min1(min1), .sec10(sec10),
    .sec1(sec1), .adj(adj), .sel(sel), .an(an0), .seg(seg0));

  seg_scan_blink #(.REFRESH_DIV(4), .BLINK_DIV(16), .DP_SEP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .min10(min10), .min1(min1), .sec10(sec10),
    .sec1(sec1), .adj(adj), .sel(sel), .an(an1), .seg(seg1));

  // Expected outputs for the edge with s prior edges and b prior adj edges.
  function automatic exp_t calc(input int sc, input int bc);
    exp_t e;
    int idx;
    logic [3:0] d;
    logic [7:0] sv;
    logic blank;
    idx = (sc / 4) % 4;
    d = (idx == 0) ? min10 : (idx == 1) ? min1 : (idx == 2) ? sec10 : sec1;
    sv = seg_tab[d];
    blank = adj && (((bc / 16) % 2) == 1) && (sel ? (idx < 2) : (idx >= 2));
    e.tag = tag_n;
    if (blank) begin
      e.an = 4'b1111; e.seg0 = 8'hFF; e.seg1 = 8'hFF;
    end else begin
      e.an = an_tab[idx]; e.seg0 = sv;
      e.seg1 = (idx == 1) ? {1'b0, sv[6:0]} : sv;
    end
    return e;
  endfunction

  // Issue n clock edges with current inputs, queueing expectations.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(calc(s, b));
      tag_n = tag_n + 16'd1;
      s = s + 1;
      b = adj ? b + 1 : 0;
      @(negedge clk);
    end
  endtask

  // Check the reset-blank state without a clock edge.
  task automatic probe_reset();
    exp_t e;
    e.an = 4'b1111; e.seg0 = 8'hFF; e.seg1 = 8'hFF; e.tag = tag_n;
    tag_n = tag_n + 16'd1;
    sb_q.push_back(e);
    probe = 1'b1;
    #2;
    checks = checks + 1;
    if (an0 !== 4'b1111 || an1 !== 4'b1111 || seg0 !== 8'hFF || seg1 !== 8'hFF) begin
      errors = errors + 1;
      $display("FAIL reset state: an0=%b an1=%b seg0=%h seg1=%h, required an=1111 seg=ff",
               an0, an1, seg0, seg1);
    end
    probe = 1'b0;
  endtask

  // Monitor: one comparison per queued expectation.
  always @(posedge clk or posedge probe) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks = checks + 1;
      if (an0 !== e.an || an1 !== e.an || seg0 !== e.seg0 || seg1 !== e.seg1) begin
        errors = errors + 1;
        $display("FAIL out#%0d: an0=%b an1=%b seg0=%h seg1=%h, required an=%b seg0=%h seg1=%h",
                 e.tag, an0, an1, seg0, seg1, e.an, e.seg0, e.seg1);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    #100000;
    if (!done) begin
      errors = errors + 1;
      $display("FAIL timeout: stimulus did not complete, %0d checks, %0d errors", checks, errors);
      $finish;
    end else begin
      $display("watchdog idle");
    end
  end

  initial begin
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
    seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
    for (int i = 10; i < 16; i++) seg_tab[i] = 8'hFF;
    an_tab[0] = 4'b0111; an_tab[1] = 4'b1011; an_tab[2] = 4'b1101; an_tab[3] = 4'b1110;

    // Reset state and scan order.
    min10 = 4'd1; min1 = 4'd2; sec10 = 4'd3; sec1 = 4'd4;
    repeat (2) @(negedge clk);
    probe_reset();
    rst = 1'b0; s = 0; b = 0;
    step(40);

    // Invalid BCD on min10; min1=0 shows the separator dot on dut1.
    min10 = 4'hC; min1 = 4'd0; sec10 = 4'd0; sec1 = 4'd7;
    step(16);

    // Seconds pair blinking.
    min10 = 4'd5; min1 = 4'd9; sec10 = 4'd5; sec1 = 4'd9;
    adj = 1'b1; sel = 1'b0;
    step(84);            // ends inside a blank phase
    sel = 1'b1;          // switch to minutes pair mid-blank
    step(36);            // crosses visible back into blank phase

    // Adjust exit during blank, then re-entry starts visible.
    adj = 1'b0;
    step(8);
    adj = 1'b1;
    step(20);

    // Asynchronous reset mid idx2 slot.
    adj = 1'b0;
    while (((s / 4) % 4) != 2 || (s % 4) != 2) step(1);
    rst = 1'b1;
    probe_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; s = 0; b = 0;
    step(8);

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_blink.md
Name: seg_scan_blink

Overview:
- Downstream display stage of the stopwatch: consumes the four BCD digits (min10, min1, sec10, sec1) plus the adjust controls.
- Time-multiplexes the digits onto the 4-digit common-anode 7-segment display.
- While adjusting, blinks the selected digit pair.
- Replaces ad-hoc scan logic in the top level. All timing comes from internal clock-enable counters on the single system clock, not derived clocks.

Parameters:
REFRESH_DIV, 250000, system-clock cycles per digit slot (100 MHz -> 400 Hz slot rate, 100 Hz frame)
BLINK_DIV, 25000000, system-clock cycles per blink phase (100 MHz -> 0.25 s per phase, 2 Hz blink)
DP_SEP, 0, when 1, light the decimal point on the min1 digit as the min/sec separator

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
min10  in  4  BCD tens of minutes
min1  in  4  BCD units of minutes
sec10  in  4  BCD tens of seconds
sec1  in  4  BCD units of seconds
adj  in  1  adjust mode active (level)
sel  in  1  adjust select: 0 = seconds pair, 1 = minutes pair
an  out  4  digit anodes, active-low, an[3] = leftmost
seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (async assert, any cycle):
  - refresh_cnt=0, idx=0, blink_cnt=0, phase=1 (visible).
  - an=4'b1111, seg=8'hFF.
- refresh_cnt counts 0..REFRESH_DIV-1.
  - On the terminal count it wraps to 0 and idx advances 0->1->2->3->0.
- Digit mapping:
  - idx0 = min10, an 4'b0111
  - idx1 = min1, an 4'b1011
  - idx2 = sec10, an 4'b1101
  - idx3 = sec1, an 4'b1110
- an and seg are registered.
  - Each cycle they load the function of the current idx, digit inputs, adj, sel and phase.
  - Latency is 1 cycle from any input or idx change to the outputs. No inputs are latched beyond that.
- Decode:
  - 0 = 8'hC0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90.
  - Any code >9 decodes to 8'hFF (blank). The digit is still scanned, with an active.
- DP: when DP_SEP=1 and idx=1, seg[7]=0. Otherwise seg[7]=1.
- Blink counter, when adj=0:
  - blink_cnt is held at 0 and phase=1.
  - Leaving adjust therefore restores full display on the next cycle, and every new adjust entry starts visible.
- Blink counter, when adj=1:
  - blink_cnt counts 0..BLINK_DIV-1.
  - On the terminal count it wraps to 0 and phase toggles.
- Blanking:
  - Applies when adj=1 and phase=0 and idx belongs to the selected pair (sel=0 -> idx2/3; sel=1 -> idx0/1).
  - A blanked slot drives an=4'b1111 and seg=8'hFF.
  - The non-selected pair always displays normally.
- sel changing while adj=1: takes effect on the next cycle; the blink phase is not restarted.
- Simultaneous refresh and blink terminal counts in one cycle: both update; the output reflects both on the following cycle.
- Scan continues regardless of adj/sel; the refresh counter is never held.
- Reset mid-frame: outputs blank immediately (async); scanning restarts at idx0 on the first clk edge after release.
- Counter widths are $clog2 of the divider, minimum 1. Parameters <1 are illegal.

Decomposition:
- Shared package (stopwatch_pkg):
  - SEG_BLANK=8'hFF
  - the 10-entry active-low segment constants
  - AN_IDX0..AN_IDX3 patterns, AN_OFF=4'b1111
  - shared with any other display consumer.
- Sub-module bcd_seg_lut: combinational 4-bit BCD -> 8-bit active-low pattern with blank default. Instantiated once on the muxed digit.
- Divider/scan/blink counters stay in seg_scan_blink.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16, DP_SEP=0 unless stated):
- Scan order: digits=1,2,3,4, adj=0, hold 40 cycles after reset release.
  - an cycles 0111 -> 1011 -> 1101 -> 1110, each slot 4 cycles.
  - seg = F9, A4, B0, 99 respectively.
  - During rst=1: an=1111, seg=FF.
- Invalid BCD and DP: min10=4'hC, DP_SEP=1.
  - idx0 slot: an=0111, seg=FF.
  - idx1 slot with min1=0: seg=8'h40.
- Blink seconds: digits=5,9,5,9, adj=1, sel=0.
  - First 16 cycles: all four digits display.
  - Next 16 cycles: idx2/3 slots give an=1111, seg=FF, while idx0/1 show 92/90.
  - The pattern repeats.
- Blink minutes / sel switch:
  - sel=1 during a blank phase: the minutes slots blank and the seconds slots show on the next cycle.
  - Phase timing is unchanged.
- Adjust exit: drop adj during a blank phase -> next cycle all slots display. Re-raise adj -> the first 16 cycles are visible.
- Async reset mid-slot: assert rst between clk edges at idx2.
  - an=1111, seg=FF with no clock edge.
  - After release, the first update shows an=0111.
